// File: rtl/line_feeder.sv
`default_nettype none
// line_feeder: walks line-buffer words from a base address and serialises them
// MSB-first into 1/2/4/8-bpp pixels, with fine scroll on the first word. rev 1.0
module line_feeder #(
  parameter int DW = 16,
  parameter int AW = 9,
  parameter int FW = 4
) (
  input  logic          dotclk_i,
  input  logic          rst_i,
  input  logic          scanline_en_i,
  input  logic [1:0]    mode_i,
  input  logic [AW-1:0] base_adr_i,
  input  logic [AW-1:0] words_i,
  input  logic [FW-1:0] fine_i,
  input  logic [DW-1:0] f_dat_i,
  output logic [AW-1:0] f_adr_o,
  output logic          load_o,
  output logic [7:0]    pix_o,
  output logic          pix_valid_o,
  output logic          done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [DW-1:0] shifter;
  logic [FW-1:0] pctr;
  logic [FW-1:0] fine_q;
  logic [1:0]    mode_q;
  logic [AW-1:0] words_left;

  logic [3:0]    bpp;
  logic [FW-1:0] ppw_m1;
  logic [FW-1:0] fine_m;
  logic [FW+3:0] shamt;
  logic [DW-1:0] prime_sh;
  logic [DW-1:0] run_sh;
  logic          last_px;

  function automatic logic [7:0] top_pix(input logic [DW-1:0] sh, input logic [1:0] m);
    case (m)
      2'd0:    top_pix = {7'd0, sh[DW-1]};
      2'd1:    top_pix = {6'd0, sh[DW-1 -: 2]};
      2'd2:    top_pix = {4'd0, sh[DW-1 -: 4]};
      default: top_pix = sh[DW-1 -: 8];
    endcase
  endfunction

  // Next-pixel values are computed here so every output can be registered.
  always_comb begin
    bpp      = 4'd1 << mode_q;
    ppw_m1   = FW'((DW >> mode_q) - 1);
    fine_m   = fine_i & FW'((DW >> mode_i) - 1);
    shamt    = (FW+4)'(fine_q) * (FW+4)'(bpp);
    prime_sh = f_dat_i << shamt;
    run_sh   = shifter << bpp;
    last_px  = (pctr == ppw_m1);
  end

  always_ff @(posedge dotclk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      f_adr_o     <= '0;
      load_o      <= 1'b0;
      pix_o       <= '0;
      pix_valid_o <= 1'b0;
      done_o      <= 1'b0;
      shifter     <= '0;
      pctr        <= '0;
      fine_q      <= '0;
      mode_q      <= '0;
      words_left  <= '0;
    end else begin
      case (state)
        IDLE: begin
          f_adr_o     <= '0;
          load_o      <= 1'b0;
          pix_o       <= '0;
          pix_valid_o <= 1'b0;
          done_o      <= 1'b0;
          if (scanline_en_i) begin
            if (words_i != '0) begin
              mode_q     <= mode_i;
              fine_q     <= fine_m;
              words_left <= words_i;
              f_adr_o    <= base_adr_i;
              load_o     <= 1'b1;
              state      <= PRIME;
            end else begin
              done_o <= 1'b1;
              state  <= DONE;
            end
          end
        end

        PRIME: begin
          if (!scanline_en_i) begin
            state       <= IDLE;
            f_adr_o     <= '0;
            load_o      <= 1'b0;
            pix_o       <= '0;
            pix_valid_o <= 1'b0;
          end else begin
            shifter     <= prime_sh;
            pctr        <= fine_q;
            f_adr_o     <= f_adr_o + 1'b1;
            words_left  <= words_left - 1'b1;
            pix_o       <= top_pix(prime_sh, mode_q);
            pix_valid_o <= 1'b1;
            // A fully scrolled first word may need a reload on its only pixel.
            load_o      <= (fine_q == ppw_m1) && (words_left != AW'(1));
            state       <= RUN;
          end
        end

        RUN: begin
          if (!scanline_en_i) begin
            state       <= IDLE;
            f_adr_o     <= '0;
            load_o      <= 1'b0;
            pix_o       <= '0;
            pix_valid_o <= 1'b0;
          end else if (last_px && (words_left != '0)) begin
            shifter     <= f_dat_i;
            pctr        <= '0;
            f_adr_o     <= f_adr_o + 1'b1;
            words_left  <= words_left - 1'b1;
            pix_o       <= top_pix(f_dat_i, mode_q);
            load_o      <= (ppw_m1 == '0) && (words_left != AW'(1));
          end else if (last_px) begin
            state       <= DONE;
            done_o      <= 1'b1;
            load_o      <= 1'b0;
            pix_o       <= '0;
            pix_valid_o <= 1'b0;
          end else begin
            shifter     <= run_sh;
            pctr        <= pctr + 1'b1;
            pix_o       <= top_pix(run_sh, mode_q);
            load_o      <= ((pctr + 1'b1) == ppw_m1) && (words_left != '0);
          end
        end

        default: begin
          done_o      <= 1'b0;
          load_o      <= 1'b0;
          pix_o       <= '0;
          pix_valid_o <= 1'b0;
          if (!scanline_en_i) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_feeder.sv
`default_nettype none
// tb_line_feeder: scoreboard bench for line_feeder; expected pixels are queued
// from a line-buffer model when a line starts and popped as pixels appear.
module tb_line_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scanline_en = 1'b0;
  logic [1:0]  mode = '0;
  logic [8:0]  base_adr = '0;
  logic [8:0]  words = '0;
  logic [3:0]  fine = '0;
  logic [15:0] f_dat;
  logic [8:0]  f_adr;
  logic        load;
  logic [7:0]  pix;
  logic        pix_valid;
  logic        done;

  logic [15:0] mem [0:511];
  assign f_dat = mem[f_adr];

  typedef struct packed {
    logic [7:0] pix;
    logic       load;
    logic [8:0] adr;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  logic mon_en = 1'b0;
  logic exp_prev_valid = 1'b1;
  logic [8:0] exp_prime_adr = '0;
  logic prev_valid = 1'b0;
  logic prev_done = 1'b0;

  line_feeder #(.DW(16), .AW(9), .FW(4)) dut (
    .dotclk_i      (clk),
    .rst_i         (rst),
    .scanline_en_i (scanline_en),
    .mode_i        (mode),
    .base_adr_i    (base_adr),
    .words_i       (words),
    .fine_i        (fine),
    .f_dat_i       (f_dat),
    .f_adr_o       (f_adr),
    .load_o        (load),
    .pix_o         (pix),
    .pix_valid_o   (pix_valid),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (pix_valid) begin
        check("pix_pending", q.size() != 0, 1);
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          check("pix", pix, mon_e.pix);
          check("run_load", load, mon_e.load);
          check("run_adr", f_adr, mon_e.adr);
        end
      end else if (load) begin
        check("prime_adr", f_adr, exp_prime_adr);
      end
      if (done) begin
        done_cnt++;
        check("done_after_last", prev_valid, exp_prev_valid);
        check("done_pulse", prev_done, 0);
        check("done_q_empty", q.size(), 0);
      end
    end
    prev_valid = pix_valid;
    prev_done  = done;
  end

  task automatic push_line(input logic [1:0] m, input logic [8:0] b,
                           input logic [8:0] w, input logic [3:0] f);
    int ppw, bpp, fm, word;
    exp_t e;
    bpp = 1 << m;
    ppw = 16 / bpp;
    fm  = int'(f) & (ppw - 1);
    for (int wi = 0; wi < int'(w); wi++) begin
      word = int'(mem[(int'(b) + wi) % 512]);
      for (int p = 0; p < ppw; p++) begin
        if (!(wi == 0 && p < fm)) begin
          e.pix  = 8'((word >> (16 - (p + 1) * bpp)) & ((1 << bpp) - 1));
          e.load = (p == ppw - 1) && (wi != int'(w) - 1);
          e.adr  = 9'(int'(b) + wi + 1);
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic start_line(input logic [1:0] m, input logic [8:0] b,
                            input logic [8:0] w, input logic [3:0] f);
    push_line(m, b, w, f);
    exp_prev_valid = 1'b1;
    exp_prime_adr  = b;
    @(negedge clk);
    mode = m; base_adr = b; words = w; fine = f; scanline_en = 1'b1;
  endtask

  task automatic run_line(input logic [1:0] m, input logic [8:0] b,
                          input logic [8:0] w, input logic [3:0] f);
    int d0;
    d0 = done_cnt;
    start_line(m, b, w, f);
    for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
    check("done_seen", done_cnt - d0, 1);
    check("line_q_empty", q.size(), 0);
    scanline_en = 1'b0;
    mode = 2'd3; base_adr = 9'h155; words = 9'd7; fine = 4'd9;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cnt;
    int d0;
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);

    #1;
    check("rst_adr", f_adr, 0);
    check("rst_load", load, 0);
    check("rst_pix", pix, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    mem[5] = 16'h8001; mem[6] = 16'hFFFF;
    run_line(2'd0, 9'd5, 9'd2, 4'd0);

    mem[40] = 16'h1234; mem[41] = 16'h5678;
    run_line(2'd3, 9'd40, 9'd2, 4'd1);

    run_line(2'd1, 9'h1FF, 9'd2, 4'd0);
    run_line(2'd2, 9'd100, 9'd3, 4'd3);
    run_line(2'd3, 9'd200, 9'd3, 4'd7);
    run_line(2'd0, 9'd300, 9'd1, 4'd15);

    // Abort after five pixels.
    start_line(2'd0, 9'd20, 9'd4, 4'd0);
    d0 = done_cnt;
    cnt = 0;
    for (int i = 0; i < 50 && cnt < 5; i++) begin
      @(negedge clk);
      if (pix_valid) cnt++;
    end
    check("abort_reach5", cnt, 5);
    scanline_en = 1'b0;
    @(negedge clk);
    check("abort_valid", pix_valid, 0);
    check("abort_load", load, 0);
    check("abort_adr", f_adr, 0);
    q.delete();
    repeat (4) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);

    // Blank line.
    exp_prev_valid = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    words = 9'd0; scanline_en = 1'b1;
    @(negedge clk);
    check("blank_done_lat", done, 1);
    for (int i = 0; i < 3; i++) begin
      check("blank_load", load, 0);
      check("blank_valid", pix_valid, 0);
      @(negedge clk);
    end
    check("blank_done_cnt", done_cnt - d0, 1);
    scanline_en = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-line.
    start_line(2'd0, 9'd60, 9'd4, 4'd2);
    repeat (8) @(negedge clk);
    check("pre_rst_valid", pix_valid, 1);
    mon_en = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_adr", f_adr, 0);
    check("arst_load", load, 0);
    check("arst_pix", pix, 0);
    check("arst_valid", pix_valid, 0);
    check("arst_done", done, 0);
    scanline_en = 1'b0;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    mem[70] = 16'hA5C3; mem[71] = 16'h0F1E;
    run_line(2'd2, 9'd70, 9'd2, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
